pipe_hazard_tracker: RTL and testbench

Parametrised hazard and forwarding controller for the mide pipeline family. It supersedes the fixed two-source MEM/WB forwarding check with a registered in-flight write chain of configurable depth and per-class result-ready stages, so load-use and multi-cycle producers stall correctly. The block sits beside the decode stage. It takes the issuing instruction's sources and destination and returns the ID stall and the EX-stage operand-forward selects. It also counts stall and flush events for profiling.

---
 rtl/pipe_hazard_tracker_pkg.sv | 24 ++
 rtl/pipe_hazard_tracker_if.sv | 37 +++
 rtl/pipe_hazard_tracker_match.sv | 36 +++
 rtl/pipe_hazard_tracker.sv | 101 ++++++++++
 tb/tb_pipe_hazard_tracker.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_tracker_pkg.sv
// Shared types and constants for the decode-side hazard tracker.
// Latency: none (types, constants and a pure helper only).
// Backpressure: none.
package hazard_pkg;

   // Widest register address the chain can hold; narrower addresses are zero-extended.
   localparam int RD_MAX_W = 8;

   // Forward select meaning "take the register-file operand".
   localparam int fwd_none = 0;

   // One in-flight writer: index 0 is EX, DEPTH-1 is WB.
   typedef struct packed {
      logic                valid;
      logic [RD_MAX_W-1:0] rd;
      logic                load;
   } chain_entry_t;

   // First stage index at which a producer's result can be forwarded.
   function automatic int ready_stage(input logic is_load, input int rdy_alu, input int rdy_load);
      return is_load ? rdy_load : rdy_alu;
   endfunction

endpackage

// File: rtl/pipe_hazard_tracker_if.sv
// Decode-stage hazard request/response bundle.
// Latency: stall is combinational; forward selects and counters are registered.
// Backpressure: stall holds IF/ID; there is no other flow control.
interface pipe_hazard_tracker_if #(
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 3,
   parameter int CNT_W  = 32
);
   localparam int SEL_W = $clog2(DEPTH);

   logic              id_valid;
   logic [ADDR_W-1:0] id_rs1;
   logic [ADDR_W-1:0] id_rs2;
   logic              id_use1;
   logic              id_use2;
   logic [ADDR_W-1:0] id_rd;
   logic              id_wen;
   logic              id_load;
   logic              flush;
   logic              stall;
   logic [SEL_W-1:0]  fwd_a;
   logic [SEL_W-1:0]  fwd_b;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;

   // Decode side: presents the issuing instruction, consumes stall/selects.
   modport master (
      output id_valid, id_rs1, id_rs2, id_use1, id_use2, id_rd, id_wen, id_load, flush,
      input  stall, fwd_a, fwd_b, stall_cnt, flush_cnt
   );

   // Tracker side.
   modport slave (
      input  id_valid, id_rs1, id_rs2, id_use1, id_use2, id_rd, id_wen, id_load, flush,
      output stall, fwd_a, fwd_b, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipe_hazard_tracker_match.sv
// Youngest-match priority encoder of one source address over the write chain.
// Latency: combinational.
// Backpressure: none.
module hazard_match
   import hazard_pkg::*;
#(
   parameter int ADDR_W   = 5,
   parameter int DEPTH    = 3,
   parameter int ZERO_REG = 1
) (
   input  chain_entry_t              chain [DEPTH],
   input  logic [ADDR_W-1:0]         src,
   input  logic                      use_src,
   output logic                      hit,
   output logic [$clog2(DEPTH)-1:0]  idx,
   output logic                      is_load
);
   localparam int IDX_W = $clog2(DEPTH);

   logic src_ok;

   // Scan oldest to youngest so the lowest matching index is the one left standing.
   always_comb begin
      hit     = 1'b0;
      idx     = '0;
      is_load = 1'b0;
      src_ok  = use_src && !((ZERO_REG != 0) && (src == '0));
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (src_ok && chain[k].valid && (chain[k].rd == RD_MAX_W'(src))) begin
            hit     = 1'b1;
            idx     = IDX_W'(k);
            is_load = chain[k].load;
         end
      end
   end
endmodule

// File: rtl/pipe_hazard_tracker.sv
// In-flight write chain producing the ID stall and registered EX forward selects.
// Latency: stall is combinational; fwd_a/fwd_b land one cycle later in the consumer's EX cycle.
// Backpressure: stall holds IF/ID and bubbles EX; flush overrides stall.
module pipe_hazard_tracker
   import hazard_pkg::*;
#(
   parameter int ADDR_W   = 5,
   parameter int DEPTH    = 3,
   parameter int RDY_ALU  = 1,
   parameter int RDY_LOAD = 2,
   parameter int ZERO_REG = 1,
   parameter int CNT_W    = 32
) (
   input logic                 clk,
   input logic                 rst,
   pipe_hazard_tracker_if.slave hz
);
   localparam int SEL_W = $clog2(DEPTH);

   chain_entry_t     chain [DEPTH];
   logic             hit_a, hit_b;
   logic             load_a, load_b;
   logic [SEL_W-1:0] idx_a, idx_b;
   logic [SEL_W-1:0] sel_a, sel_b;
   logic             haz_a, haz_b;
   logic             rd_is_zero;
   logic             issue;
   logic             no_fwd;

   // Producer at k reaches stage k+1 in the consumer's EX; stall while that is short of ready.
   // WB (k = DEPTH-1) never stalls because the register file writes through.
   function automatic logic src_haz(input logic hit, input logic [SEL_W-1:0] idx, input logic ld);
      return hit && (int'(idx) <= DEPTH - 2) &&
             (int'(idx) + 1 < ready_stage(ld, RDY_ALU, RDY_LOAD));
   endfunction

   function automatic logic [SEL_W-1:0] src_sel(input logic hit, input logic [SEL_W-1:0] idx);
      return (hit && (int'(idx) <= DEPTH - 2)) ? SEL_W'(int'(idx) + 1) : SEL_W'(fwd_none);
   endfunction

   hazard_match #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG)) u_match_a (
      .chain   (chain),
      .src     (hz.id_rs1),
      .use_src (hz.id_use1),
      .hit     (hit_a),
      .idx     (idx_a),
      .is_load (load_a)
   );

   hazard_match #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG)) u_match_b (
      .chain   (chain),
      .src     (hz.id_rs2),
      .use_src (hz.id_use2),
      .hit     (hit_b),
      .idx     (idx_b),
      .is_load (load_b)
   );

   assign haz_a = src_haz(hit_a, idx_a, load_a);
   assign haz_b = src_haz(hit_b, idx_b, load_b);
   assign sel_a = src_sel(hit_a, idx_a);
   assign sel_b = src_sel(hit_b, idx_b);

   // Flush kills the ID instruction, so it also masks any stall it would have raised.
   assign hz.stall   = hz.id_valid & ~hz.flush & (haz_a | haz_b);
   assign rd_is_zero = (ZERO_REG != 0) && (hz.id_rd == '0);
   assign issue      = hz.id_valid & hz.id_wen & ~hz.stall & ~hz.flush & ~rd_is_zero;
   assign no_fwd     = hz.stall | hz.flush | ~hz.id_valid;

   // Shift the chain every cycle; entry 0 takes the issuing writer or a bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) chain[k] <= '0;
      end else begin
         chain[0] <= issue ? '{valid: 1'b1, rd: RD_MAX_W'(hz.id_rd), load: hz.id_load} : '0;
         for (int k = 1; k < DEPTH; k++) chain[k] <= chain[k-1];
      end
   end

   // Register the EX operand selects; a bubble or killed instruction forwards nothing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hz.fwd_a <= SEL_W'(fwd_none);
         hz.fwd_b <= SEL_W'(fwd_none);
      end else begin
         hz.fwd_a <= no_fwd ? SEL_W'(fwd_none) : sel_a;
         hz.fwd_b <= no_fwd ? SEL_W'(fwd_none) : sel_b;
      end
   end

   // Saturating stall/flush event counters for profiling.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hz.stall_cnt <= '0;
         hz.flush_cnt <= '0;
      end else begin
         if (hz.stall && (hz.stall_cnt != '1)) hz.stall_cnt <= hz.stall_cnt + CNT_W'(1);
         if (hz.flush && (hz.flush_cnt != '1)) hz.flush_cnt <= hz.flush_cnt + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_pipe_hazard_tracker.sv
// Directed bench for pipe_hazard_tracker with a forward-select scoreboard queue.
// Latency: stall checked in the issue cycle, selects popped one edge later.
// Backpressure: a second instance with 4-bit counters checks saturation.
module tb_pipe_hazard_tracker;

   logic clk = 1'b0;
   logic rst;
   int   nvec = 0;
   int   nmis = 0;
   logic [3:0] exp_q [$];

   always #5 clk = ~clk;

   pipe_hazard_tracker_if #(.ADDR_W(5), .DEPTH(3), .CNT_W(32)) hz  ();
   pipe_hazard_tracker_if #(.ADDR_W(5), .DEPTH(3), .CNT_W(4))  hz4 ();

   assign hz4.id_valid = hz.id_valid;
   assign hz4.id_rs1   = hz.id_rs1;
   assign hz4.id_rs2   = hz.id_rs2;
   assign hz4.id_use1  = hz.id_use1;
   assign hz4.id_use2  = hz.id_use2;
   assign hz4.id_rd    = hz.id_rd;
   assign hz4.id_wen   = hz.id_wen;
   assign hz4.id_load  = hz.id_load;
   assign hz4.flush    = hz.flush;

   pipe_hazard_tracker #(.ADDR_W(5), .DEPTH(3), .RDY_ALU(1), .RDY_LOAD(2), .ZERO_REG(1), .CNT_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz)
   );

   pipe_hazard_tracker #(.ADDR_W(5), .DEPTH(3), .RDY_ALU(1), .RDY_LOAD(2), .ZERO_REG(1), .CNT_W(4)) dut4 (
      .clk (clk),
      .rst (rst),
      .hz  (hz4)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      assert (got === exp) else begin
         nmis++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic wen, input logic ld, input logic fl);
      hz.id_valid = v;
      hz.id_rs1   = rs1;
      hz.id_use1  = u1;
      hz.id_rs2   = rs2;
      hz.id_use2  = u2;
      hz.id_rd    = rd;
      hz.id_wen   = wen;
      hz.id_load  = ld;
      hz.flush    = fl;
   endtask

   // Check stall now, queue the selects this issue should produce, pop them after the edge.
   task automatic cycle(input string tag, input logic es, input logic [1:0] ea, input logic [1:0] eb);
      logic [3:0] e;
      #1;
      chk({tag, " stall"}, 32'(hz.stall), 32'(es));
      exp_q.push_back({ea, eb});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk({tag, " fwd_a"}, 32'(hz.fwd_a), 32'(e[3:2]));
      chk({tag, " fwd_b"}, 32'(hz.fwd_b), 32'(e[1:0]));
   endtask

   task automatic idle(input int n);
      for (int j = 0; j < n; j++) begin
         drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
         cycle("idle", 1'b0, 2'd0, 2'd0);
      end
   endtask

   // Hard time limit so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("reset stall", 32'(hz.stall), 32'd0);
      chk("reset fwd_a", 32'(hz.fwd_a), 32'd0);
      chk("reset fwd_b", 32'(hz.fwd_b), 32'd0);
      chk("reset stall_cnt", hz.stall_cnt, 32'd0);
      chk("reset flush_cnt", hz.flush_cnt, 32'd0);
      chk("reset stall_cnt4", 32'(hz4.stall_cnt), 32'd0);
      rst = 1'b0;

      // Back-to-back ALU dependency: add r3, then read r3.
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
      cycle("alu prod", 1'b0, 2'd0, 2'd0);
      drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      cycle("alu use", 1'b0, 2'd1, 2'd0);
      idle(3);

      // Load-use: load r4, then read r4 on rs2.
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);
      cycle("load prod", 1'b0, 2'd0, 2'd0);
      drive(1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      cycle("load use stall", 1'b1, 2'd0, 2'd0);
      cycle("load use fwd", 1'b0, 2'd0, 2'd2);
      chk("load use stall_cnt", hz.stall_cnt, 32'd1);
      idle(3);

      // Youngest wins: r5 at MEM and r5 at EX.
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
      cycle("r5 old", 1'b0, 2'd0, 2'd0);
      cycle("r5 young", 1'b0, 2'd0, 2'd0);
      drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      cycle("youngest", 1'b0, 2'd1, 2'd0);
      idle(3);

      // Writer at MEM only forwards from stage 2.
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
      cycle("r7 prod", 1'b0, 2'd0, 2'd0);
      idle(1);
      drive(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      cycle("mem fwd", 1'b0, 2'd0, 2'd2);
      idle(3);

      // Writer at WB only: register file covers it.
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
      cycle("r6 prod", 1'b0, 2'd0, 2'd0);
      idle(2);
      drive(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      cycle("wb no fwd", 1'b0, 2'd0, 2'd0);
      idle(3);

      // Zero register: a load to r0 never creates a hazard.
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
      cycle("r0 load", 1'b0, 2'd0, 2'd0);
      drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      cycle("r0 use", 1'b0, 2'd0, 2'd0);

      // Vector address 16 is tracked like any other register.
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd16, 1'b1, 1'b1, 1'b0);
      cycle("v16 load", 1'b0, 2'd0, 2'd0);
      drive(1'b1, 5'd16, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      cycle("v16 stall", 1'b1, 2'd0, 2'd0);
      cycle("v16 fwd", 1'b0, 2'd2, 2'd0);
      chk("v16 stall_cnt", hz.stall_cnt, 32'd2);
      idle(3);

      // Flush during a load-use stall; the flushed writer r9 must become a bubble.
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);
      cycle("flush prod", 1'b0, 2'd0, 2'd0);
      drive(1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1);
      cycle("flush wins", 1'b0, 2'd0, 2'd0);
      chk("flush flush_cnt", hz.flush_cnt, 32'd1);
      chk("flush stall_cnt", hz.stall_cnt, 32'd2);
      chk("flush flush_cnt4", 32'(hz4.flush_cnt), 32'd1);
      drive(1'b1, 5'd9, 1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      cycle("after flush", 1'b0, 2'd0, 2'd2);
      idle(3);

      // Fill the chain, raise a stall, then reset mid-stall.
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0);
      cycle("fill r1", 1'b0, 2'd0, 2'd0);
      drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0);
      cycle("fill r2", 1'b0, 2'd1, 2'd0);
      drive(1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0);
      cycle("fill r3", 1'b0, 2'd0, 2'd1);
      drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("pre-reset stall", 32'(hz.stall), 32'd1);
      chk("pre-reset stall_cnt", hz.stall_cnt, 32'd2);
      rst = 1'b1;
      #1;
      chk("mid reset stall", 32'(hz.stall), 32'd0);
      chk("mid reset fwd_a", 32'(hz.fwd_a), 32'd0);
      chk("mid reset fwd_b", 32'(hz.fwd_b), 32'd0);
      chk("mid reset stall_cnt", hz.stall_cnt, 32'd0);
      chk("mid reset flush_cnt", hz.flush_cnt, 32'd0);
      chk("mid reset flush_cnt4", 32'(hz4.flush_cnt), 32'd0);
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Repeating "load r4 reading r4": stalls every other cycle, 20 stalls in 40 cycles.
      drive(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 40; i++) begin
         cycle("sat", (i % 2) == 1, ((i % 2) == 0 && i > 0) ? 2'd2 : 2'd0, 2'd0);
      end
      chk("sat stall_cnt", hz.stall_cnt, 32'd20);
      chk("sat stall_cnt4", 32'(hz4.stall_cnt), 32'd15);
      chk("sat flush_cnt", hz.flush_cnt, 32'd0);
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
